// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: definitions shared by the bit-serial arithmetic blocks.
// This package is used by serial_sub8. It is intended to be reused by the
// planned serial adder and serial multiplier.
//   state_e        : FSM state encoding (IDLE=0, SHIFT=1, DONE=2)
//   DEFAULT_WIDTH  : default operand width
//   DEFAULT_CNT_W  : bit-counter width for DEFAULT_WIDTH
//   cnt_width()    : bit-counter width for an arbitrary operand width
package serial_arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

  // The counter only has to reach w-1, so $clog2(w) bits are enough.
  // The result is clamped to 1 so that the counter never has zero width.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_sub1.sv
// full_sub1: combinational 1-bit full subtractor.
//   a  : minuend bit
//   b  : subtrahend bit
//   br : borrow in
//   d  : difference bit, a - b - br
//   bo : borrow out; high when a < b + br
module full_sub1 (
  input  logic a,
  input  logic b,
  input  logic br,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ br;
  assign bo = (~a & b) | (~a & br) | (b & br);

endmodule

// File: rtl/serial_sub8.sv
// serial_sub8: bit-serial unsigned subtractor with borrow.
// It computes diff = x - y - bin, one bit per clock, LSB first. A single
// full_sub1 cell is used, and operands and result live in shift registers.
//   clk, rst_n      : clock and asynchronous active-low reset
//   start           : request; accepted when not busy (IDLE or DONE)
//   x, y, bin       : operands and borrow-in; captured on the accepting edge
//   busy            : high for the WIDTH cycles of the shift phase
//   done            : one-cycle pulse when diff/bout are updated
//   diff, bout      : result and borrow-out; held until the next done
module serial_sub8
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               br_q, br_d;
  logic               bout_q, bout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               cell_d;
  logic               cell_bo;

  full_sub1 u_cell (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .br (br_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;

    case (state_q)
      // In the DONE cycle a new start is accepted, just as in IDLE. This
      // lets operations run back to back with no idle cycle between them.
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = x;
          b_d     = y;
          br_d    = bin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {cell_d, res_q[WIDTH-1:1]};
        br_d  = cell_bo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          // Publish only the complete word, so that partial results are
          // never visible on diff.
          diff_d  = {cell_d, res_q[WIDTH-1:1]};
          bout_d  = cell_bo;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // busy and done are decoded from the next state, so both are registered.
    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_sub8.sv
// tb_serial_sub8: scoreboard bench for serial_sub8. WIDTH=8 is the main
// instance. A second instance with WIDTH=16 covers the wide wrap-around case.
module tb_serial_sub8;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         bin = 1'b0;
  logic         busy, done, bout;
  logic [W-1:0] diff;

  logic         start16 = 1'b0;
  logic [15:0]  x16 = '0;
  logic [15:0]  y16 = '0;
  logic         bin16 = 1'b0;
  logic         busy16, done16, bout16;
  logic [15:0]  diff16;

  int   checks = 0;
  int   passes = 0;
  int   pushed = 0;
  int   dones_seen = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  serial_sub8 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
  );

  serial_sub8 #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .x(x16), .y(y16), .bin(bin16),
    .busy(busy16), .done(done16), .diff(diff16), .bout(bout16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      dones_seen++;
      if (sb_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: got done with diff=%0d bout=%0d, required no pulse",
                 diff, bout);
      end else begin
        mon_e = sb_q.pop_front();
        $display("txn: diff=%0d bout=%0d (expected diff=%0d bout=%0d)",
                 diff, bout, mon_e.diff, mon_e.bout);
        chk("diff", 32'(diff), 32'(mon_e.diff));
        chk("bout", 32'(bout), 32'(mon_e.bout));
      end
    end
  end

  // Caller is at a negedge. Waits until the block can accept, then presents
  // one start cycle. On return we are at the negedge after the accepting edge.
  task automatic issue(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic bv,
                       input logic push, input logic [W-1:0] ed, input logic eb);
    int guard;
    guard = 0;
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk("idle_timeout", 32'(busy), 32'd0);
    start = 1'b1;
    x = xv;
    y = yv;
    bin = bv;
    if (push) begin
      sb_q.push_back('{diff: ed, bout: eb});
      pushed++;
    end
    @(negedge clk);
    start = 1'b0;
    x = W'($urandom);
    y = W'($urandom);
    bin = 1'($urandom);
  endtask

  // Count negedges until done is seen, starting at 1 for the current negedge.
  task automatic wait_done(output int k);
    k = 1;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!done) chk("done_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    int           k, nb, gap;
    logic [W-1:0] xv, yv;
    logic         bv;
    logic [W:0]   full;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_diff", 32'(diff), 32'd0);
    chk("reset_bout", 32'(bout), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Put a nonzero held result on the outputs before the reset test
    issue(8'd5, 8'd3, 1'b0, 1'b1, 8'd2, 1'b0);
    wait_done(k);
    @(negedge clk);

    // 1. Reset mid-operation: the abandoned op must never produce done
    issue(8'd200, 8'd100, 1'b0, 1'b0, 8'd0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    chk("midreset_diff", 32'(diff), 32'd0);
    chk("midreset_bout", 32'(bout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_reset_busy", 32'(busy), 32'd0);
    issue(8'd99, 8'd66, 1'b0, 1'b1, 8'd33, 1'b0);
    wait_done(k);
    @(negedge clk);

    // 2. Negative result, latency and busy length
    issue(8'd66, 8'd99, 1'b0, 1'b1, 8'd223, 1'b1);
    k = 1;
    nb = busy ? 1 : 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
      if (busy) nb++;
    end
    chk("latency_cycles", 32'(k), 32'd9);
    chk("busy_cycles", 32'(nb), 32'd8);
    repeat (3) @(negedge clk);
    chk("hold_diff", 32'(diff), 32'd223);
    chk("hold_bout", 32'(bout), 32'd1);

    // 3. Borrow-in paths
    issue(8'd255, 8'd255, 1'b1, 1'b1, 8'd255, 1'b1);
    issue(8'd123, 8'd246, 1'b1, 1'b1, 8'd132, 1'b1);
    issue(8'd168, 8'd66, 1'b1, 1'b1, 8'd101, 1'b0);
    wait_done(k);
    @(negedge clk);

    // 4. Back-to-back with start held high
    start = 1'b1;
    x = 8'd55;
    y = 8'd77;
    bin = 1'b0;
    sb_q.push_back('{diff: 8'd234, bout: 1'b1});
    sb_q.push_back('{diff: 8'd65, bout: 1'b0});
    pushed += 2;
    @(negedge clk);
    x = 8'd88;
    y = 8'd22;
    bin = 1'b1;
    wait_done(k);
    @(negedge clk);
    start = 1'b0;
    gap = 1;
    while (!done && gap < 40) begin
      @(negedge clk);
      gap++;
    end
    chk("b2b_done_gap", 32'(gap), 32'd9);
    @(negedge clk);

    // 5. start during SHIFT is ignored
    issue(8'd7, 8'd11, 1'b1, 1'b1, 8'd251, 1'b1);
    @(negedge clk);
    start = 1'b1;
    x = 8'd1;
    y = 8'd1;
    bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_done(k);
    repeat (12) @(negedge clk);
    chk("ignored_start_busy", 32'(busy), 32'd0);

    // 6. Random sweep against the arithmetic reference
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      xv = W'($urandom);
      yv = W'($urandom);
      bv = 1'($urandom);
      full = {1'b0, xv} - {1'b0, yv} - (W+1)'(bv);
      issue(xv, yv, bv, 1'b1, full[W-1:0], full[W]);
    end

    // WIDTH=16 full wrap-around
    start16 = 1'b1;
    x16 = 16'd0;
    y16 = 16'd65535;
    bin16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    k = 0;
    while (!done16 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("w16_done_latency", 32'(k), 32'd16);
    chk("w16_diff", 32'(diff16), 32'd0);
    chk("w16_bout", 32'(bout16), 32'd1);

    // Drain the scoreboard
    k = 0;
    while (sb_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    repeat (12) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    chk("done_count", 32'(dones_seen), 32'(pushed));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
